dmem_handshake_ctrl: RTL and testbench

- Data-memory controller that sits directly downstream of the core's memory stage.
- Consumes the core's mem_in_s request (write_data, valid, wen, byte_not_word, yumi) and the 32-bit data address.
- Returns mem_out_s (yumi, valid, read_data) under the core's two-phase handshake: request accept, then response, then response acknowledge.
- Holds a word-organised synchronous data array with a configurable access latency, so the core's multi-cycle LD/ST stall path is exercised.

---
 rtl/dmem_handshake_ctrl_pkg.sv | 39 +++
 rtl/dmem_byte_array.sv | 47 ++++
 rtl/dmem_handshake_ctrl.sv | 123 ++++++++++++
 tb/tb_dmem_handshake_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_handshake_ctrl_pkg.sv
// Shared definitions for the data-memory handshake controller.
// Latency: n/a (types, constants and helper functions only).
// Backpressure: n/a.
package dmem_handshake_ctrl_pkg;

    // Core -> memory request. yumi here acknowledges a response.
    typedef struct packed {
        logic [31:0] write_data;
        logic        valid;
        logic        wen;
        logic        byte_not_word;
        logic        yumi;
    } mem_in_s;

    // Memory -> core response. yumi here is the request-accept strobe.
    typedef struct packed {
        logic        yumi;
        logic        valid;
        logic [31:0] read_data;
    } mem_out_s;

    // Prefixed so the names never collide with the core's own state_e.
    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_WAIT = 2'd1,
        DMEM_RESP = 2'd2
    } dmem_state_e;

    localparam int DMEM_CNT_W = 4;

    // Byte-write-enable mask for a store: one lane for byte stores, all four for words.
    function automatic logic [3:0] dmem_byte_mask(input logic byte_not_word,
                                                  input logic [1:0] lane);
        logic [3:0] mask;
        mask = byte_not_word ? (4'b0001 << lane) : 4'b1111;
        return mask;
    endfunction

endpackage

// File: rtl/dmem_byte_array.sv
// Word-organised single-port 32-bit array with per-byte write enables and a registered read.
// Latency: write lands on the enabled edge; read data appears one edge after a read-enable.
// Backpressure: none; the read register holds its value until the next read access.
//
// Ports:
//   clk, reset (async active-low, clears only the read register)
//   en     - access strobe; wen==0 with en makes a read, wen!=0 makes a byte-masked write
//   wen    - byte-write-enable, bit i covers bits [8i+7:8i]
//   addr   - word index
//   wdata  - write data (lanes not enabled are ignored)
//   rdata  - registered read data
module dmem_byte_array #(
    parameter int addr_width_p = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en,
    input  logic [3:0]              wen,
    input  logic [addr_width_p-1:0] addr,
    input  logic [31:0]             wdata,
    output logic [31:0]             rdata
);

    logic [31:0] mem [0:(2**addr_width_p)-1];

    // Storage is deliberately left out of reset so it maps onto plain SRAM.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (wen[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Only loads update the read register, so a pending response stays stable
    // and a store never disturbs it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (en && (wen == 4'b0000)) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_handshake_ctrl.sv
// Data-memory controller behind the core's memory stage: accept, fixed-latency response, acknowledge.
// Latency: response valid latency_p cycles after the accept edge, held until acknowledged.
// Backpressure: one transaction in flight; requests are only accepted in IDLE, responses wait for to_mem_i.yumi.
//
// Ports:
//   clk, reset (async active-low)
//   to_mem_i        - request fields plus response acknowledge (yumi)
//   data_mem_addr_i - byte address; word index is bits [2 +: addr_width_p], lane is bits [1:0]
//   from_mem_o      - accept strobe (yumi, combinational), response valid, read_data
//   busy_o          - high while a transaction is in flight
module dmem_handshake_ctrl
    import dmem_handshake_ctrl_pkg::*;
#(
    parameter int addr_width_p = 10,
    parameter int latency_p    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  mem_in_s     to_mem_i,
    input  logic [31:0] data_mem_addr_i,
    output mem_out_s    from_mem_o,
    output logic        busy_o
);

    localparam logic [DMEM_CNT_W-1:0] LAT_M1 = DMEM_CNT_W'(latency_p - 1);

    dmem_state_e           state;
    logic [DMEM_CNT_W-1:0] cnt;
    logic                  resp_store;
    logic                  resp_byte;
    logic [1:0]            resp_lane;

    logic                    accept;
    logic [addr_width_p-1:0] word_idx;
    logic [1:0]              lane;
    logic [3:0]              arr_wen;
    logic [31:0]             arr_wdata;
    logic [31:0]             arr_rdata;
    logic [7:0]              lane_byte;
    logic [31:0]             resp_data;
    logic                    addr_unused;

    assign word_idx = data_mem_addr_i[2 +: addr_width_p];
    assign lane     = data_mem_addr_i[1:0];

    // High address bits alias onto the array (addresses wrap modulo the depth).
    assign addr_unused = ^data_mem_addr_i[31:2+addr_width_p];

    // Gated by reset so nothing is accepted, and nothing written, while reset is held.
    assign accept = reset && (state == DMEM_IDLE) && to_mem_i.valid;

    assign arr_wen   = to_mem_i.wen ? dmem_byte_mask(to_mem_i.byte_not_word, lane) : 4'b0000;
    assign arr_wdata = to_mem_i.byte_not_word ? {4{to_mem_i.write_data[7:0]}}
                                              : to_mem_i.write_data;

    dmem_byte_array #(
        .addr_width_p (addr_width_p)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .en    (accept),
        .wen   (arr_wen),
        .addr  (word_idx),
        .wdata (arr_wdata),
        .rdata (arr_rdata)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= DMEM_IDLE;
            cnt        <= '0;
            resp_store <= 1'b0;
            resp_byte  <= 1'b0;
            resp_lane  <= 2'd0;
        end else begin
            case (state)
                DMEM_IDLE: begin
                    if (accept) begin
                        resp_store <= to_mem_i.wen;
                        resp_byte  <= to_mem_i.byte_not_word;
                        resp_lane  <= lane;
                        if (latency_p == 1) begin
                            state <= DMEM_RESP;
                        end else begin
                            state <= DMEM_WAIT;
                            cnt   <= LAT_M1;
                        end
                    end
                end
                DMEM_WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == DMEM_CNT_W'(1)) begin
                        state <= DMEM_RESP;
                    end
                end
                DMEM_RESP: begin
                    // No accept here: the next request waits for the IDLE cycle that follows.
                    if (to_mem_i.yumi) begin
                        state <= DMEM_IDLE;
                    end
                end
                default: state <= DMEM_IDLE;
            endcase
        end
    end

    // The array read register was loaded on the accept edge and is untouched
    // until the next load, so formatting it here keeps read_data stable in RESP.
    assign lane_byte = arr_rdata[{resp_lane, 3'b000} +: 8];

    always_comb begin
        resp_data = '0;
        if ((state == DMEM_RESP) && !resp_store) begin
            resp_data = resp_byte ? {24'h000000, lane_byte} : arr_rdata;
        end
    end

    assign from_mem_o.yumi      = accept;
    assign from_mem_o.valid     = (state == DMEM_RESP);
    assign from_mem_o.read_data = resp_data;
    assign busy_o               = (state != DMEM_IDLE);

endmodule

// File: tb/tb_dmem_handshake_ctrl.sv
// Self-checking bench for dmem_handshake_ctrl: directed scenarios followed by random traffic.
// Latency: expects response valid exactly LAT cycles after each accept edge.
// Backpressure: exercises withheld acknowledges and request valid held across a transaction.
module tb_dmem_handshake_ctrl;
    import dmem_handshake_ctrl_pkg::*;

    localparam int LAT = 2;
    localparam int AW  = 10;

    logic        clk = 1'b0;
    logic        reset;
    mem_in_s     to_mem_i;
    logic [31:0] data_mem_addr_i;
    mem_out_s    from_mem_o;
    logic        busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Byte-addressed image of the whole array: index = byte address modulo depth*4.
    logic [7:0]  mb [0:(4<<AW)-1];
    logic [31:0] exp_rd;

    always #5 clk = ~clk;

    dmem_handshake_ctrl #(
        .addr_width_p (AW),
        .latency_p    (LAT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .to_mem_i        (to_mem_i),
        .data_mem_addr_i (data_mem_addr_i),
        .from_mem_o      (from_mem_o),
        .busy_o          (busy_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference: plain byte memory, little-endian words, stores answer zero.
    task automatic model_access(input bit wen, input bit bnw, input logic [31:0] a,
                                input logic [31:0] wd, output logic [31:0] rd);
        int b;
        int wb;
        b  = int'(a) & ((4 << AW) - 1);
        wb = b & ~3;
        rd = 32'h0;
        if (wen) begin
            if (bnw) mb[b] = wd[7:0];
            else for (int i = 0; i < 4; i++) mb[wb+i] = wd[8*i +: 8];
        end else if (bnw) begin
            rd = {24'h0, mb[b]};
        end else begin
            rd = {mb[wb+3], mb[wb+2], mb[wb+1], mb[wb]};
        end
    endtask

    // Valid and accept must never coincide.
    always @(negedge clk) begin
        #2;
        if (reset === 1'b1)
            check_eq("valid_yumi_excl", {31'h0, from_mem_o.valid & from_mem_o.yumi}, 32'h0);
    end

    // Called just after a negedge while the DUT is idle. Returns at the negedge of
    // the first response cycle with the response checked.
    task automatic run_req(input bit wen, input bit bnw, input logic [31:0] a,
                           input logic [31:0] wd, input bit hold);
        to_mem_i.valid         = 1'b1;
        to_mem_i.wen           = wen;
        to_mem_i.byte_not_word = bnw;
        to_mem_i.write_data    = wd;
        to_mem_i.yumi          = 1'b0;
        data_mem_addr_i        = a;
        #1;
        check_eq("accept_yumi", {31'h0, from_mem_o.yumi}, 32'h1);
        check_eq("idle_busy", {31'h0, busy_o}, 32'h0);
        check_eq("idle_valid", {31'h0, from_mem_o.valid}, 32'h0);
        model_access(wen, bnw, a, wd, exp_rd);
        @(posedge clk);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            check_eq("no_reaccept", {31'h0, from_mem_o.yumi}, 32'h0);
            check_eq("resp_timing", {31'h0, from_mem_o.valid}, (k == LAT) ? 32'h1 : 32'h0);
            check_eq("busy_inflight", {31'h0, busy_o}, 32'h1);
            if (!hold) to_mem_i.valid = 1'b0;
        end
        check_eq("read_data", from_mem_o.read_data, exp_rd);
    endtask

    // Withhold the acknowledge for ack_wait cycles, then acknowledge and return
    // at the negedge of the following IDLE cycle.
    task automatic finish_resp(input int ack_wait);
        for (int k = 0; k < ack_wait; k++) begin
            @(negedge clk);
            check_eq("resp_hold_valid", {31'h0, from_mem_o.valid}, 32'h1);
            check_eq("resp_hold_data", from_mem_o.read_data, exp_rd);
            check_eq("resp_hold_noacc", {31'h0, from_mem_o.yumi}, 32'h0);
        end
        to_mem_i.valid = 1'b0;
        to_mem_i.yumi  = 1'b1;
        @(negedge clk);
        to_mem_i.yumi = 1'b0;
        check_eq("ack_drop_valid", {31'h0, from_mem_o.valid}, 32'h0);
        check_eq("ack_idle_busy", {31'h0, busy_o}, 32'h0);
    endtask

    task automatic do_req(input bit wen, input bit bnw, input logic [31:0] a,
                          input logic [31:0] wd, input bit hold, input int ack_wait);
        run_req(wen, bnw, a, wd, hold);
        finish_resp(ack_wait);
    endtask

    int unsigned pool [8] = '{4, 5, 100, 1023, 0, 512, 7, 300};

    initial begin
        logic [31:0] a;
        reset                  = 1'b0;
        to_mem_i               = '0;
        to_mem_i.valid         = 1'b1;
        data_mem_addr_i        = 32'h0;

        // Reset: outputs forced low even with a request pending.
        repeat (2) @(negedge clk);
        check_eq("rst_yumi", {31'h0, from_mem_o.yumi}, 32'h0);
        check_eq("rst_valid", {31'h0, from_mem_o.valid}, 32'h0);
        check_eq("rst_rdata", from_mem_o.read_data, 32'h0);
        check_eq("rst_busy", {31'h0, busy_o}, 32'h0);
        to_mem_i.valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);

        // Word store, word load with withheld acknowledge.
        do_req(1, 0, 32'h10, 32'hDEADBEEF, 0, 1);
        do_req(0, 0, 32'h10, 32'h0, 0, 3);

        // Byte store into lane 3, then byte and word readback.
        do_req(1, 1, 32'h13, 32'hFFFFFF5A, 0, 0);
        do_req(0, 1, 32'h13, 32'h0, 0, 0);
        do_req(0, 0, 32'h10, 32'h0, 0, 0);
        check_eq("byte_merge", exp_rd, 32'h5AADBEEF);

        // Address wrap modulo the array depth.
        do_req(1, 0, 32'h1010, 32'h12345678, 0, 0);
        do_req(0, 0, 32'h0010, 32'h0, 0, 1);

        // Valid held through WAIT/RESP, and a new request coincident with the acknowledge.
        run_req(1, 0, 32'h20, 32'hA5A5_0F0F, 1);
        to_mem_i.valid         = 1'b1;
        to_mem_i.wen           = 1'b0;
        to_mem_i.byte_not_word = 1'b0;
        data_mem_addr_i        = 32'h20;
        to_mem_i.yumi          = 1'b1;
        #1;
        check_eq("no_accept_on_ack", {31'h0, from_mem_o.yumi}, 32'h0);
        @(negedge clk);
        to_mem_i.yumi = 1'b0;
        check_eq("chain_idle_valid", {31'h0, from_mem_o.valid}, 32'h0);
        run_req(0, 0, 32'h20, 32'h0, 1);
        finish_resp(0);

        // Reset during WAIT of a load; an earlier store must survive.
        do_req(1, 0, 32'h44, 32'hCAFEF00D, 0, 0);
        to_mem_i.valid         = 1'b1;
        to_mem_i.wen           = 1'b0;
        to_mem_i.byte_not_word = 1'b0;
        data_mem_addr_i        = 32'h44;
        #1;
        check_eq("pre_rst_accept", {31'h0, from_mem_o.yumi}, 32'h1);
        @(negedge clk);
        check_eq("pre_rst_busy", {31'h0, busy_o}, 32'h1);
        reset = 1'b0;
        #1;
        check_eq("midrst_yumi", {31'h0, from_mem_o.yumi}, 32'h0);
        check_eq("midrst_valid", {31'h0, from_mem_o.valid}, 32'h0);
        check_eq("midrst_rdata", from_mem_o.read_data, 32'h0);
        check_eq("midrst_busy", {31'h0, busy_o}, 32'h0);
        @(negedge clk);
        to_mem_i.valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        do_req(0, 0, 32'h44, 32'h0, 0, 0);
        check_eq("store_survives_rst", exp_rd, 32'hCAFEF00D);

        // Random traffic over a small word pool so accesses collide and alias.
        foreach (pool[i]) begin
            a = ($urandom & 32'hFFFF_F000) | (pool[i] << 2);
            do_req(1, 0, a, $urandom, 0, 0);
        end
        for (int n = 0; n < 80; n++) begin
            a = ($urandom & 32'hFFFF_F000) | (pool[$urandom_range(0, 7)] << 2)
                | 32'($urandom_range(0, 3));
            do_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
                   1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
